seq_chk: RTL and testbench

//   Downstream consumer of the seq_gen 4-bit output stream. Checks that each valid sample

---
 rtl/seq_chk_pkg.sv | 20 ++
 rtl/seq_chk_sat_cnt.sv | 24 ++
 rtl/seq_chk.sv | 120 ++++++++++++
 tb/tb_seq_chk.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/seq_chk_pkg.sv
// Shared definitions for the sequence checker: state encodings, default data width
// and the sizing helper for the run/miss counters.
package seq_chk_pkg;

  localparam int SEQ_DW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Width able to hold 0..max(a,b) inclusive.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = '1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_chk.sv
// Checks a valid-qualified stream for a constant modular increment, acquires and
// loses lock on runs of good/bad steps, and counts mismatches seen while locked.
module seq_chk
  import seq_chk_pkg::*;
#(
  parameter int DW     = SEQ_DW,
  parameter int STEP   = 1,
  parameter int LOCK_N = 3,
  parameter int LOSE_N = 2,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          clr,
  output logic          locked,
  output logic          err_pulse,
  output logic [CW-1:0] err_cnt,
  output logic [1:0]    state
);

  localparam int RW = cnt_width(LOCK_N, LOSE_N);
  localparam logic [DW-1:0] STEP_V = DW'(STEP);
  localparam logic [RW-1:0] LOCK_V = RW'(LOCK_N);
  localparam logic [RW-1:0] LOSE_V = RW'(LOSE_N);

  state_t        state_reg, state_next;
  logic [DW-1:0] prev_reg, prev_next;
  logic [RW-1:0] run_reg, run_next;
  logic [RW-1:0] miss_reg, miss_next;
  logic          pulse_next;
  logic          locked_next;
  logic [DW-1:0] exp_val;
  logic [RW-1:0] run_inc;
  logic [RW-1:0] miss_inc;
  logic          match;

  assign exp_val  = prev_reg + STEP_V;
  assign match    = (in_data == exp_val);
  assign run_inc  = run_reg + 1'b1;
  assign miss_inc = miss_reg + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      prev_reg  <= '0;
      run_reg   <= '0;
      miss_reg  <= '0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_reg <= state_next;
      prev_reg  <= prev_next;
      run_reg   <= run_next;
      miss_reg  <= miss_next;
      err_pulse <= pulse_next;
      locked    <= locked_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    run_next   = run_reg;
    miss_next  = miss_reg;
    pulse_next = 1'b0;
    if (in_valid) begin
      case (state_reg)
        ST_IDLE: begin
          prev_next  = in_data;
          run_next   = '0;
          state_next = ST_ACQ;
        end
        ST_ACQ: begin
          prev_next = in_data;
          if (match) begin
            run_next = run_inc;
            if (run_inc == LOCK_V) begin
              state_next = ST_LOCKED;
              miss_next  = '0;
            end
          end else begin
            run_next = '0;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            miss_next = '0;
            prev_next = in_data;
          end else begin
            // Flywheel on the expected value so one corrupt sample costs one error.
            pulse_next = 1'b1;
            miss_next  = miss_inc;
            prev_next  = exp_val;
            if (miss_inc == LOSE_V) begin
              state_next = ST_ACQ;
              run_next   = '0;
              miss_next  = '0;
              prev_next  = in_data;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
    locked_next = (state_next == ST_LOCKED);
  end

  sat_cnt #(.W(CW)) u_err_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (pulse_next),
    .clr   (clr),
    .count (err_cnt)
  );

  assign state = state_reg;

endmodule

// File: tb/tb_seq_chk.sv
// Directed scoreboard bench: each step queues its hand-computed expected outputs and a
// negedge monitor pops and compares them against a CW=8 and a CW=2 instance.
module tb_seq_chk;

  typedef struct {
    int l;
    int p;
    int c;
    int s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       clr = 1'b0;

  logic       locked, err_pulse, locked2, err_pulse2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [1:0] state, state2;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_chk #(.CW(8)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .state(state)
  );

  seq_chk #(.CW(2)) dut2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .state(state2)
  );

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      int   c2;
      e  = q.pop_front();
      c2 = (e.c > 3) ? 3 : e.c;
      check("locked", int'(locked), e.l);
      check("err_pulse", int'(err_pulse), e.p);
      check("err_cnt", int'(err_cnt), e.c);
      check("state", int'(state), e.s);
      check("err_cnt_cw2", int'(err_cnt2), c2);
      $display("txn t=%0t v=%0d d=%0d clr=%0d -> locked=%0d pulse=%0d cnt=%0d cnt2=%0d state=%0d",
               $time, in_valid, in_data, clr, locked, err_pulse, err_cnt, err_cnt2, state);
    end
  end

  task automatic step(input int v, input int d, input int c,
                      input int el, input int ep, input int ec, input int es);
    exp_t e;
    in_valid = v[0];
    in_data  = d[3:0];
    clr      = c[0];
    e.l = el; e.p = ep; e.c = ec; e.s = es;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  initial begin
    #12 rstn = 1'b1;

    // Reset state, then a clean ramp with the 15->0 wrap.
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      if (i < 3) step(1, i % 16, 0, 0, 0, 0, 1);
      else       step(1, i % 16, 0, 1, 0, 0, 2);
    end

    // Single corrupt sample while locked.
    for (int d = 2; d <= 5; d++) step(1, d, 0, 1, 0, 0, 2);
    step(1, 9, 0, 1, 1, 1, 2);
    step(1, 7, 0, 1, 0, 1, 2);
    step(1, 8, 0, 1, 0, 1, 2);

    // Two consecutive misses drop lock; three good steps re-lock.
    step(1, 0, 0, 1, 1, 2, 2);
    step(1, 0, 0, 0, 1, 3, 1);
    step(1, 1, 0, 0, 0, 3, 1);
    step(1, 2, 0, 0, 0, 3, 1);
    step(1, 3, 0, 1, 0, 3, 2);

    // Gaps of 1..5 idle cycles between samples.
    for (int k = 1; k <= 5; k++) begin
      for (int g = 0; g < k; g++) step(0, 0, 0, 1, 0, 3, 2);
      step(1, 3 + k, 0, 1, 0, 3, 2);
    end
    step(1, 0, 0, 1, 1, 4, 2);
    step(0, 0, 0, 1, 0, 4, 2);
    step(1, 10, 0, 1, 0, 4, 2);

    // Clear, then five isolated errors (CW=2 instance saturates at 3).
    step(0, 0, 1, 1, 0, 0, 2);
    step(1, 0, 0, 1, 1, 1, 2);
    step(1, 12, 0, 1, 0, 1, 2);
    step(1, 0, 0, 1, 1, 2, 2);
    step(1, 14, 0, 1, 0, 2, 2);
    step(1, 5, 0, 1, 1, 3, 2);
    step(1, 0, 0, 1, 0, 3, 2);
    step(1, 5, 0, 1, 1, 4, 2);
    step(1, 2, 0, 1, 0, 4, 2);
    step(1, 9, 0, 1, 1, 5, 2);
    step(1, 4, 0, 1, 0, 5, 2);
    step(1, 0, 1, 1, 1, 0, 2);
    step(1, 6, 0, 1, 0, 0, 2);

    // Asynchronous reset mid-lock, off the clock edge.
    #5 rstn = 1'b0;
    #1;
    check("async_locked", int'(locked), 0);
    check("async_err_cnt", int'(err_cnt), 0);
    check("async_state", int'(state), 0);
    check("async_pulse", int'(err_pulse), 0);
    check("async_err_cnt_cw2", int'(err_cnt2), 0);
    #5 rstn = 1'b1;

    // Fresh acquisition including a resync in ACQ.
    step(1, 7, 0, 0, 0, 0, 1);
    step(1, 3, 0, 0, 0, 0, 1);
    step(1, 4, 0, 0, 0, 0, 1);
    step(1, 5, 0, 0, 0, 0, 1);
    step(1, 6, 0, 1, 0, 0, 2);
    step(0, 0, 0, 1, 0, 0, 2);

    for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clk);
    #6;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
